fwd_hazard_ctrl: RTL and testbench

- Next-generation forwarding and hazard unit for the 32-bit pipelined core.
- Generalises operand forwarding to NUM_SRC source operands and adds a registered post-WB bypass (history) stage.
- Adds a load-use stall counter for multi-cycle data memory and a single-entry scoreboard for fixed-latency multicycle ops (MUL/DIV).
- Sits between ID/EX pipeline registers and the EX operand muxes; drives stall/bubble to the hazard path.

---
 rtl/fwd_pkg.sv | 15 +
 rtl/fwd_hazard_ctrl_if.sv | 46 ++++
 rtl/fwd_src_sel.sv | 31 +++
 rtl/fwd_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and defaults for the forwarding / hazard unit.
//   fwd_sel_t      - per-operand bypass select (00 regfile, 01 WB, 10 MEM, 11 history)
//   DEF_REG_ADDR_W - default register index width
package fwd_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_HIST = 2'b11
  } fwd_sel_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: pipeline-side bundle for the forwarding / hazard unit.
//   master - the pipeline: drives ID/EX/MEM/WB state and mc_start, reads the
//            bypass selects, history data and stall/bubble controls.
//   slave  - the hazard unit itself (directions mirrored).
interface fwd_hazard_ctrl_if
  import fwd_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_SRC    = 2
);

  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex;
  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id;
  logic [NUM_SRC-1:0]            rs_id_used;
  logic                          mc_id;
  logic [REG_ADDR_W-1:0]         rd_ex;
  logic                          reg_write_ex;
  logic                          mem_read_ex;
  logic [REG_ADDR_W-1:0]         rd_mem;
  logic                          reg_write_mem;
  logic [REG_ADDR_W-1:0]         rd_wb;
  logic                          reg_write_wb;
  logic [XLEN-1:0]               wb_data;
  logic                          mc_start;
  logic [REG_ADDR_W-1:0]         mc_rd;
  logic [2*NUM_SRC-1:0]          fwd_sel;
  logic [XLEN-1:0]               hist_data;
  logic                          stall_id;
  logic                          flush_ex;
  logic                          mc_busy;
  logic                          mc_err;

  modport master (
    output rs_ex, rs_id, rs_id_used, mc_id, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, reg_write_mem, rd_wb, reg_write_wb, wb_data, mc_start, mc_rd,
    input  fwd_sel, hist_data, stall_id, flush_ex, mc_busy, mc_err
  );

  modport slave (
    input  rs_ex, rs_id, rs_id_used, mc_id, rd_ex, reg_write_ex, mem_read_ex,
           rd_mem, reg_write_mem, rd_wb, reg_write_wb, wb_data, mc_start, mc_rd,
    output fwd_sel, hist_data, stall_id, flush_ex, mc_busy, mc_err
  );

endinterface

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: combinational bypass select for one source operand.
// Priority MEM > WB > history > regfile; x0 never forwards.
//   rs          - source register of this operand in EX
//   rd_*/we_*   - destination and write enable of MEM, WB and history stages
//   sel         - resulting fwd_sel_t
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_mem,
  input  logic                  we_mem,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  we_wb,
  input  logic [REG_ADDR_W-1:0] hist_rd,
  input  logic                  hist_valid,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_RF;
    if (we_mem && rd_mem != '0 && rd_mem == rs)
      sel = FWD_MEM;
    else if (we_wb && rd_wb != '0 && rd_wb == rs)
      sel = FWD_WB;
    else if (hist_valid && hist_rd != '0 && hist_rd == rs)
      sel = FWD_HIST;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding and hazard control between the ID/EX
// pipeline registers and the EX operand muxes.
//   clk, rst_n - core clock, asynchronous active-low reset
//   bus        - fwd_hazard_ctrl_if.slave: EX/MEM/WB destinations and write
//                enables, ID/EX sources, WB data, multicycle start; returns
//                fwd_sel, hist_data, stall_id, flush_ex, mc_busy, mc_err.
// Build option FWD_WB_HIST_EN: when defined, a one-cycle post-WB history
// bypass is built (fwd_sel may be 11). When undefined the regfile must be
// write-through, fwd_sel never selects history and hist_data is 0.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_STALL = 1,
  parameter int MC_LAT     = 4
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  localparam int LD_W = $clog2(LOAD_STALL + 1);
  localparam int MC_W = $clog2(MC_LAT + 1);

  logic                  hist_valid;
  logic [REG_ADDR_W-1:0] hist_rd;
  fwd_sel_t              sel_raw [NUM_SRC];
  logic [2*NUM_SRC-1:0]  fwd_sel_c;

  logic [LD_W-1:0]       ld_cnt;
  logic [MC_W-1:0]       mc_cnt;
  logic                  mc_busy_q;
  logic [REG_ADDR_W-1:0] mc_rd_q;
  logic                  mc_err_q;

  logic                  ld_match;
  logic                  mc_match;
  logic                  ld_hit;
  logic                  stall;

`ifdef FWD_WB_HIST_EN
  logic [XLEN-1:0] hist_data_q;

  // Catches a WB write the regfile has not yet made visible; lives one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_valid  <= 1'b0;
      hist_rd     <= '0;
      hist_data_q <= '0;
    end else if (bus.reg_write_wb && bus.rd_wb != '0) begin
      hist_valid  <= 1'b1;
      hist_rd     <= bus.rd_wb;
      hist_data_q <= bus.wb_data;
    end else begin
      hist_valid  <= 1'b0;
    end
  end

  assign bus.hist_data = hist_data_q;
`else
  logic unused_wb_data;

  assign hist_valid     = 1'b0;
  assign hist_rd        = '0;
  assign bus.hist_data  = '0;
  assign unused_wb_data = ^bus.wb_data;
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
      .rs         (bus.rs_ex[i*REG_ADDR_W +: REG_ADDR_W]),
      .rd_mem     (bus.rd_mem),
      .we_mem     (bus.reg_write_mem),
      .rd_wb      (bus.rd_wb),
      .we_wb      (bus.reg_write_wb),
      .hist_rd    (hist_rd),
      .hist_valid (hist_valid),
      .sel        (sel_raw[i])
    );
  end

  // Selects are forced to regfile while reset is held so the EX muxes see a
  // clean state immediately, not at the next edge.
  always_comb begin
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst_n)
        fwd_sel_c[2*i +: 2] = sel_raw[i];
    end
  end

  assign bus.fwd_sel = fwd_sel_c;

  // Dependency of any used ID source on the EX load or the pending mc result.
  always_comb begin
    ld_match = 1'b0;
    mc_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.rs_id_used[i] && bus.rs_id[i*REG_ADDR_W +: REG_ADDR_W] == bus.rd_ex)
        ld_match = 1'b1;
      if (bus.rs_id_used[i] && bus.rs_id[i*REG_ADDR_W +: REG_ADDR_W] == mc_rd_q)
        mc_match = 1'b1;
    end
  end

  assign ld_hit = bus.mem_read_ex && bus.reg_write_ex && (bus.rd_ex != '0) && ld_match;

  assign stall = rst_n && ((ld_cnt != '0) || ld_hit ||
                           (mc_busy_q && mc_rd_q != '0 && mc_match) ||
                           (mc_busy_q && bus.mc_id));

  // The cycle of the hit is the first bubble, so the counter covers the
  // remaining LOAD_STALL-1. The mc counter runs MC_LAT busy cycles; a start
  // while busy is dropped and only flags mc_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt    <= '0;
      mc_cnt    <= '0;
      mc_busy_q <= 1'b0;
      mc_rd_q   <= '0;
      mc_err_q  <= 1'b0;
    end else begin
      if (ld_cnt != '0)
        ld_cnt <= ld_cnt - LD_W'(1);
      else if (ld_hit)
        ld_cnt <= LD_W'(LOAD_STALL - 1);

      if (mc_busy_q) begin
        if (mc_cnt == MC_W'(1)) begin
          mc_busy_q <= 1'b0;
          mc_cnt    <= '0;
        end else begin
          mc_cnt    <= mc_cnt - MC_W'(1);
        end
        if (bus.mc_start)
          mc_err_q <= 1'b1;
      end else if (bus.mc_start) begin
        mc_busy_q <= 1'b1;
        mc_rd_q   <= bus.mc_rd;
        mc_cnt    <= MC_W'(MC_LAT);
      end
    end
  end

  assign bus.stall_id = stall;
  assign bus.flush_ex = stall;
  assign bus.mc_busy  = mc_busy_q;
  assign bus.mc_err   = mc_err_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scoreboard bench for fwd_hazard_ctrl with
// LOAD_STALL=3, MC_LAT=4, NUM_SRC=2. Each step drives one cycle of pipeline
// state, pushes the expected outputs, and compares them on the falling edge.
module tb_fwd_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int NSRC = 2;
  localparam int LDS  = 3;
  localparam int MCL  = 4;

`ifdef FWD_WB_HIST_EN
  localparam logic [3:0] HIST_OP1 = 4'b1100;
`else
  localparam logic [3:0] HIST_OP1 = 4'b0000;
`endif

  typedef struct packed {
    logic [9:0]  rs_ex;
    logic [9:0]  rs_id;
    logic [1:0]  used;
    logic        mc_id;
    logic [4:0]  rd_ex;
    logic        reg_write_ex;
    logic        mem_read_ex;
    logic [4:0]  rd_mem;
    logic        reg_write_mem;
    logic [4:0]  rd_wb;
    logic        reg_write_wb;
    logic [31:0] wb_data;
    logic        mc_start;
    logic [4:0]  mc_rd;
  } stim_t;

  typedef struct {
    string       tag;
    logic [3:0]  fwd;
    logic [31:0] hist;
    logic        stall;
    logic        busy;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  exp_t        sbQ[$];
  logic [31:0] histModel;
  int          checkCount;
  int          passCount;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .NUM_SRC(NSRC)) bus_if ();

  fwd_hazard_ctrl #(
    .XLEN(XLEN), .REG_ADDR_W(RAW), .NUM_SRC(NSRC), .LOAD_STALL(LDS), .MC_LAT(MCL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else
      passCount++;
  endtask

  task automatic driveInputs(input stim_t s);
    bus_if.rs_ex         = s.rs_ex;
    bus_if.rs_id         = s.rs_id;
    bus_if.rs_id_used    = s.used;
    bus_if.mc_id         = s.mc_id;
    bus_if.rd_ex         = s.rd_ex;
    bus_if.reg_write_ex  = s.reg_write_ex;
    bus_if.mem_read_ex   = s.mem_read_ex;
    bus_if.rd_mem        = s.rd_mem;
    bus_if.reg_write_mem = s.reg_write_mem;
    bus_if.rd_wb         = s.rd_wb;
    bus_if.reg_write_wb  = s.reg_write_wb;
    bus_if.wb_data       = s.wb_data;
    bus_if.mc_start      = s.mc_start;
    bus_if.mc_rd         = s.mc_rd;
  endtask

  task automatic compareOutputs();
    exp_t e;
    e = sbQ.pop_front();
    checkOutput({e.tag, ".fwd_sel"},   {28'd0, bus_if.fwd_sel},  {28'd0, e.fwd});
    checkOutput({e.tag, ".hist_data"}, bus_if.hist_data,         e.hist);
    checkOutput({e.tag, ".stall_id"},  {31'd0, bus_if.stall_id}, {31'd0, e.stall});
    checkOutput({e.tag, ".flush_ex"},  {31'd0, bus_if.flush_ex}, {31'd0, e.stall});
    checkOutput({e.tag, ".mc_busy"},   {31'd0, bus_if.mc_busy},  {31'd0, e.busy});
    checkOutput({e.tag, ".mc_err"},    {31'd0, bus_if.mc_err},   {31'd0, e.err});
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic applyStimulus(input string tag, input stim_t s, input logic [3:0] fwd,
                               input logic stall, input logic busy, input logic err);
    exp_t e;
    driveInputs(s);
    e.tag   = tag;
    e.fwd   = fwd;
    e.hist  = histModel;
    e.stall = stall;
    e.busy  = busy;
    e.err   = err;
    sbQ.push_back(e);
`ifdef FWD_WB_HIST_EN
    if (s.reg_write_wb && s.rd_wb != '0)
      histModel = s.wb_data;
`endif
    @(negedge clk);
    compareOutputs();
    @(posedge clk);
    #1;
  endtask

  task automatic asyncResetCheck(input string tag);
    exp_t e;
    rst_n     = 1'b0;
    histModel = '0;
    e.tag   = tag;
    e.fwd   = '0;
    e.hist  = '0;
    e.stall = 1'b0;
    e.busy  = 1'b0;
    e.err   = 1'b0;
    sbQ.push_back(e);
    #1;
    compareOutputs();
  endtask

  initial begin
    stim_t s;
    checkCount = 0;
    passCount  = 0;
    histModel  = '0;
    rst_n      = 1'b0;

    s = idleStim();
    s.rd_mem = 5'd5; s.reg_write_mem = 1'b1; s.rs_ex = {5'd0, 5'd5};
    driveInputs(s);
    #3;
    asyncResetCheck("rst_init");
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priority and x0
    s = idleStim();
    s.rd_mem = 5'd5; s.reg_write_mem = 1'b1; s.rd_wb = 5'd5; s.reg_write_wb = 1'b1;
    s.wb_data = 32'h1111_1111; s.rs_ex = {5'd0, 5'd5};
    applyStimulus("fwd_mem_over_wb", s, 4'b0010, 1'b0, 1'b0, 1'b0);
    s.reg_write_mem = 1'b0;
    applyStimulus("fwd_wb", s, 4'b0001, 1'b0, 1'b0, 1'b0);
    s = idleStim();
    s.rd_mem = 5'd0; s.reg_write_mem = 1'b1; s.rs_ex = 10'd0;
    applyStimulus("fwd_x0", s, 4'b0000, 1'b0, 1'b0, 1'b0);

    // History bypass
    s = idleStim();
    s.rd_wb = 5'd7; s.reg_write_wb = 1'b1; s.wb_data = 32'hDEAD_BEEF;
    applyStimulus("hist_wr", s, 4'b0000, 1'b0, 1'b0, 1'b0);
    s = idleStim();
    s.rs_ex = {5'd7, 5'd0};
    applyStimulus("hist_fwd", s, HIST_OP1, 1'b0, 1'b0, 1'b0);
    applyStimulus("hist_gone", s, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Load-use: unused operand must not stall, used one stalls LDS cycles
    s = idleStim();
    s.rd_ex = 5'd4; s.reg_write_ex = 1'b1; s.mem_read_ex = 1'b1;
    s.rs_id = {5'd4, 5'd3}; s.used = 2'b01;
    applyStimulus("ld_unused", s, 4'b0000, 1'b0, 1'b0, 1'b0);
    s = idleStim();
    applyStimulus("ld_unused_after", s, 4'b0000, 1'b0, 1'b0, 1'b0);
    s.rd_ex = 5'd4; s.reg_write_ex = 1'b1; s.mem_read_ex = 1'b1;
    s.rs_id = {5'd0, 5'd4}; s.used = 2'b01;
    applyStimulus("ld_hit", s, 4'b0000, 1'b1, 1'b0, 1'b0);
    s.rd_ex = 5'd0; s.reg_write_ex = 1'b0; s.mem_read_ex = 1'b0;
    applyStimulus("ld_stall2", s, 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("ld_stall3", s, 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus("ld_done", s, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Multicycle on x9 with a rejected second start
    s = idleStim();
    s.mc_start = 1'b1; s.mc_rd = 5'd9; s.rs_id = {5'd0, 5'd9}; s.used = 2'b01;
    applyStimulus("mc_go", s, 4'b0000, 1'b0, 1'b0, 1'b0);
    s.mc_start = 1'b0; s.mc_rd = 5'd0;
    applyStimulus("mc_b1", s, 4'b0000, 1'b1, 1'b1, 1'b0);
    s.mc_start = 1'b1; s.mc_rd = 5'd12;
    applyStimulus("mc_b2_restart", s, 4'b0000, 1'b1, 1'b1, 1'b0);
    s.mc_start = 1'b0; s.mc_rd = 5'd0; s.rs_id = {5'd0, 5'd12};
    applyStimulus("mc_b3_rd_kept", s, 4'b0000, 1'b0, 1'b1, 1'b1);
    s.rs_id = {5'd0, 5'd9};
    applyStimulus("mc_b4", s, 4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus("mc_done", s, 4'b0000, 1'b0, 1'b0, 1'b1);

    // mc_rd=0: busy without data stall, structural stall via mc_id
    s = idleStim();
    s.mc_start = 1'b1; s.mc_rd = 5'd0;
    applyStimulus("mc0_go", s, 4'b0000, 1'b0, 1'b0, 1'b1);
    s = idleStim();
    s.rs_id = 10'd0; s.used = 2'b01;
    applyStimulus("mc0_nodata", s, 4'b0000, 1'b0, 1'b1, 1'b1);
    s.mc_id = 1'b1;
    applyStimulus("mc0_struct", s, 4'b0000, 1'b1, 1'b1, 1'b1);
    s.mc_id = 1'b0;
    applyStimulus("mc0_b3", s, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus("mc0_b4", s, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus("mc0_done", s, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Load-use starting inside an mc stall keeps its full length
    s = idleStim();
    s.mc_start = 1'b1; s.mc_rd = 5'd9; s.rs_id = {5'd0, 5'd9}; s.used = 2'b01;
    applyStimulus("mix_go", s, 4'b0000, 1'b0, 1'b0, 1'b1);
    s = idleStim();
    s.rd_ex = 5'd4; s.reg_write_ex = 1'b1; s.mem_read_ex = 1'b1;
    s.rs_id = {5'd4, 5'd9}; s.used = 2'b11;
    applyStimulus("mix_both", s, 4'b0000, 1'b1, 1'b1, 1'b1);
    s = idleStim();
    s.rs_id = {5'd4, 5'd0}; s.used = 2'b10;
    applyStimulus("mix_ld2", s, 4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus("mix_ld3", s, 4'b0000, 1'b1, 1'b1, 1'b1);
    applyStimulus("mix_ld_end", s, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus("mix_mc_end", s, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Async reset mid load-use stall and mid multicycle op
    s = idleStim();
    s.rd_mem = 5'd5; s.reg_write_mem = 1'b1; s.rs_ex = {5'd0, 5'd5};
    s.rd_ex = 5'd4; s.reg_write_ex = 1'b1; s.mem_read_ex = 1'b1;
    s.rs_id = {5'd0, 5'd4}; s.used = 2'b01; s.mc_start = 1'b1; s.mc_rd = 5'd9;
    applyStimulus("pre_rst_start", s, 4'b0010, 1'b1, 1'b0, 1'b1);
    s.rd_ex = 5'd0; s.reg_write_ex = 1'b0; s.mem_read_ex = 1'b0;
    s.mc_start = 1'b0; s.mc_rd = 5'd0; s.rs_id = {5'd0, 5'd9};
    applyStimulus("pre_rst_busy", s, 4'b0010, 1'b1, 1'b1, 1'b1);
    #2;
    asyncResetCheck("rst_mid");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_rst", s, 4'b0010, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
